// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the memory stage
package mem_pkg;

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} mem_state_t;

  localparam int DATA_MEM_BASE = 1024;
  localparam int SRAM_DW       = 16;

endpackage

// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - two half-word access sequencer for a 16-bit asynchronous SRAM
// Drives the SRAM pins from registers and assembles load data from two captures.
module sram_ctrl
  import mem_pkg::*;
#(
  parameter int ACCESS_CYCLES = 2,
  parameter int SRAM_AW       = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req,
  input  logic               wr,
  input  logic [SRAM_AW-2:0] word,
  input  logic [31:0]        wdata,
  output mem_state_t         state,
  output logic [31:0]        rdata,
  inout  wire  [SRAM_DW-1:0] SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_WE_N,
  output logic               SRAM_OE_N
);

  localparam int            CW   = $clog2(ACCESS_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(ACCESS_CYCLES - 1);

  logic [CW-1:0]      cnt;
  logic               drive;
  logic [SRAM_DW-1:0] dq_out;

  assign SRAM_DQ = drive ? dq_out : 'z;

  // Pin registers are loaded on the edge that enters each phase so they line up with state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rdata     <= '0;
      SRAM_ADDR <= '0;
      SRAM_WE_N <= 1'b1;
      SRAM_OE_N <= 1'b1;
      drive     <= 1'b0;
      dq_out    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            state     <= LOW;
            cnt       <= '0;
            SRAM_ADDR <= {word, 1'b0};
            SRAM_WE_N <= !wr;
            SRAM_OE_N <= wr;
            drive     <= wr;
            dq_out    <= wdata[15:0];
          end
        end
        LOW: begin
          if (cnt == LAST) begin
            state     <= HIGH;
            cnt       <= '0;
            SRAM_ADDR <= {word, 1'b1};
            dq_out    <= wdata[31:16];
            if (!SRAM_OE_N) rdata[15:0] <= SRAM_DQ;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HIGH: begin
          if (cnt == LAST) begin
            state     <= DONE;
            cnt       <= '0;
            SRAM_ADDR <= '0;
            SRAM_WE_N <= 1'b1;
            SRAM_OE_N <= 1'b1;
            drive     <= 1'b0;
            if (!SRAM_OE_N) rdata[31:16] <= SRAM_DQ;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory stage: 32-bit load/store over a 16-bit SRAM
// Maps the byte address to an SRAM word and freezes the pipeline while an access runs.
module mem_stage
  import mem_pkg::*;
#(
  parameter int ACCESS_CYCLES = 2,
  parameter int BASE_ADDR     = DATA_MEM_BASE,
  parameter int SRAM_AW       = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               MEM_R_EN,
  input  logic               MEM_W_EN,
  input  logic [31:0]        ALU_Res,
  input  logic [31:0]        Val_Rm,
  output logic [31:0]        mem_rdata,
  output logic               ready,
  inout  wire  [SRAM_DW-1:0] SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_WE_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_CE_N,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N
);

  logic       req;
  logic       wr;
  logic [31:0] offset;
  mem_state_t state;

  assign req    = MEM_R_EN | MEM_W_EN;
  assign wr     = MEM_W_EN & ~MEM_R_EN;  // a request with both enables is a load
  assign offset = ALU_Res - 32'(BASE_ADDR);
  assign ready  = !req || (state == DONE);

  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

  // Byte-in-word bits and address bits beyond the SRAM are intentionally dropped.
  wire unused_offset_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};

  sram_ctrl #(
    .ACCESS_CYCLES(ACCESS_CYCLES),
    .SRAM_AW      (SRAM_AW)
  ) u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .wr       (wr),
    .word     (offset[SRAM_AW:2]),
    .wdata    (Val_Rm),
    .state    (state),
    .rdata    (mem_rdata),
    .SRAM_DQ  (SRAM_DQ),
    .SRAM_ADDR(SRAM_ADDR),
    .SRAM_WE_N(SRAM_WE_N),
    .SRAM_OE_N(SRAM_OE_N)
  );

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - randomized self-checking bench for mem_stage (ACCESS_CYCLES 2 and 1)
`timescale 1ns/1ps
module tb_mem_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             clr;
  logic [1:0]       r_en;
  logic [1:0]       w_en;
  logic [1:0][31:0] alu;
  logic [1:0][31:0] vrm;
  wire  [1:0]       rdy;
  wire  [1:0][31:0] rd_a;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g
    localparam int N = 2 - gi;
    wire        ready, we_n, oe_n, ce_n, ub_n, lb_n;
    wire [31:0] mem_rdata;
    wire [17:0] sram_addr;
    wire [15:0] dq;
    logic [15:0] sram [0:255];
    logic [15:0] refm [0:255];
    int          wcnt = 0;
    logic [17:0] wlast = '0;
    int          k = 0;
    logic [31:0] exp_rdata = '0;

    mem_stage #(.ACCESS_CYCLES(N)) dut (
      .clk(clk), .rst(rst), .MEM_R_EN(r_en[gi]), .MEM_W_EN(w_en[gi]),
      .ALU_Res(alu[gi]), .Val_Rm(vrm[gi]), .mem_rdata(mem_rdata), .ready(ready),
      .SRAM_DQ(dq), .SRAM_ADDR(sram_addr), .SRAM_WE_N(we_n), .SRAM_OE_N(oe_n),
      .SRAM_CE_N(ce_n), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n)
    );

    assign rdy[gi]  = ready;
    assign rd_a[gi] = mem_rdata;
    // SRAM drives stored data on reads; otherwise a marker shows up if nobody drives the bus.
    assign dq = we_n ? (oe_n ? 16'h5A5A : sram[sram_addr[7:0]]) : 16'hzzzz;

    // A write commits only after the strobe has been held N cycles at one address.
    always @(posedge clk) begin : sram_model
      int c;
      if (clr) begin
        for (int j = 0; j < 256; j++) sram[j] <= 16'h0;
        wcnt <= 0;
      end else begin
        c = !we_n ? ((wcnt > 0 && sram_addr == wlast) ? wcnt + 1 : 1) : 0;
        wcnt  <= c;
        wlast <= sram_addr;
        if (c == N) sram[sram_addr[7:0]] <= dq;
      end
    end

    // Model: k = cycles since the request was first seen in IDLE.
    always @(negedge clk) begin : cmp
      logic [31:0] off;
      logic [16:0] w;
      logic [7:0]  lo_i, hi_i;
      logic [17:0] ea;
      bit          req, wr, act;
      if (clr) begin
        for (int j = 0; j < 256; j++) refm[j] = 16'h0;
        k = 0;
        exp_rdata = '0;
      end else begin
        req  = r_en[gi] | w_en[gi];
        wr   = w_en[gi] & !r_en[gi];
        off  = alu[gi] - 32'd1024;
        w    = off[18:2];
        lo_i = {w[6:0], 1'b0};
        hi_i = {w[6:0], 1'b1};
        act  = (k >= 1 && k <= 2 * N);
        ea   = act ? {w, (k > N)} : 18'd0;
        if (req && !wr && k == 2 * N + 1) exp_rdata = {refm[hi_i], refm[lo_i]};

        chk($sformatf("n%0d ready k%0d", N, k), ready, !req || (k == 2 * N + 1));
        chk($sformatf("n%0d we_n k%0d", N, k), we_n, !(act && wr));
        chk($sformatf("n%0d oe_n k%0d", N, k), oe_n, !(act && !wr));
        chk($sformatf("n%0d addr k%0d", N, k), sram_addr, ea);
        chk($sformatf("n%0d ties", N), {ce_n, ub_n, lb_n}, 3'b000);
        if (!(req && !wr && k > N && k <= 2 * N))
          chk($sformatf("n%0d rdata k%0d", N, k), mem_rdata, exp_rdata);
        if (act && wr)
          chk($sformatf("n%0d dq wr k%0d", N, k), dq, (k <= N) ? vrm[gi][15:0] : vrm[gi][31:16]);
        else if (act)
          chk($sformatf("n%0d dq rd k%0d", N, k), dq, sram[ea[7:0]]);
        else
          chk($sformatf("n%0d dq idle", N), dq, 16'h5A5A);
        if (wr && k == 2 * N + 1) begin
          chk($sformatf("n%0d sram lo", N), sram[lo_i], refm[lo_i]);
          chk($sformatf("n%0d sram hi", N), sram[hi_i], refm[hi_i]);
        end

        if (rst) begin
          k = 0;
          exp_rdata = '0;
        end else begin
          if (wr && k == N)     refm[lo_i] = vrm[gi][15:0];
          if (wr && k == 2 * N) refm[hi_i] = vrm[gi][31:16];
          k = (req && k != 2 * N + 1) ? k + 1 : 0;
        end
      end
    end
  end

  task automatic op(input int d, input bit r, input bit w, input logic [31:0] a,
                    input logic [31:0] v, output int stalls);
    int n;
    n = 2 - d;
    r_en[d] = r; w_en[d] = w; alu[d] = a; vrm[d] = v;
    stalls = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rdy[d]) break;
      stalls++;
    end
    chk($sformatf("stall count d%0d", d), stalls, (r || w) ? 2 * n + 1 : 0);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int d);
    r_en[d] = 1'b0; w_en[d] = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s;
    rst = 1'b1; clr = 1'b1;
    r_en = '0; w_en = '0; alu = '0; vrm = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; clr = 1'b0;
    @(negedge clk);
    chk("reset rdata", rd_a[0], 32'h0);
    chk("reset we_n", g[0].we_n, 1'b1);
    @(posedge clk); #1;

    op(0, 0, 1, 32'd1024, 32'hDEADBEEF, s); chk("store stalls", s, 5);
    idle(0); @(negedge clk);
    chk("hw0", g[0].sram[0], 16'hBEEF);
    chk("hw1", g[0].sram[1], 16'hDEAD);
    @(posedge clk); #1;

    op(0, 1, 0, 32'd1024, 32'h0, s); chk("load stalls", s, 5);
    chk("load rdata", rd_a[0], 32'hDEADBEEF);
    idle(0); repeat (3) @(posedge clk); #1;
    chk("load held", rd_a[0], 32'hDEADBEEF);

    op(0, 0, 1, 32'd1028, 32'h12345678, s);
    idle(0); @(negedge clk);
    chk("hw2", g[0].sram[2], 16'h5678);
    chk("hw3", g[0].sram[3], 16'h1234);
    chk("hw0 kept", g[0].sram[0], 16'hBEEF);
    chk("hw1 kept", g[0].sram[1], 16'hDEAD);
    chk("rdata after write", rd_a[0], 32'hDEADBEEF);
    @(posedge clk); #1;

    op(0, 0, 0, 32'd2000, 32'hFFFFFFFF, s); chk("noop stalls", s, 0);
    op(0, 1, 0, 32'd1028, 32'h0, s);
    op(0, 1, 0, 32'd1024, 32'h0, s);
    chk("b2b rdata", rd_a[0], 32'hDEADBEEF);
    idle(0); @(posedge clk); #1;

    r_en[0] = 1'b0; w_en[0] = 1'b1; alu[0] = 32'd1024; vrm[0] = 32'hCAFEF00D;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; idle(0);
    @(negedge clk);
    chk("rst we_n", g[0].we_n, 1'b1);
    chk("rst rdata", rd_a[0], 32'h0);
    chk("rst hw0", g[0].sram[0], 16'hF00D);
    chk("rst hw1", g[0].sram[1], 16'hDEAD);
    @(posedge clk); #1;

    op(1, 0, 1, 32'd1032, 32'hA5A53C3C, s); chk("n1 store stalls", s, 3);
    op(1, 1, 0, 32'd1032, 32'h0, s); chk("n1 load stalls", s, 3);
    chk("n1 rdata", rd_a[1], 32'hA5A53C3C);
    op(1, 1, 1, 32'd1032, 32'h77777777, s); chk("n1 both stalls", s, 3);
    idle(1); @(negedge clk);
    chk("n1 both no write", g[1].sram[4], 16'h3C3C);
    @(posedge clk); #1;

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 60; i++) begin
        int kind;
        kind = $urandom_range(0, 3);
        op(d, kind[0], kind[1], 32'd1024 + 4 * $urandom_range(0, 127) + $urandom_range(0, 3),
           $urandom, s);
        if ($urandom_range(0, 1) == 1) begin
          idle(d); @(posedge clk); #1;
        end
      end
      idle(d);
    end
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
